// File: rtl/rgb_fader.sv
// rgb_fader: 3-bit colour code to {R,G,B} word, with instant or
// linear per-channel fade, valid/ready intake and a done pulse.
module rgb_fader #(
   parameter int CH_WIDTH = 8,
   parameter int STEP     = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic [2:0]              colour,
   input  logic                    mode,
   input  logic                    colour_valid,
   output logic                    colour_ready,
   output logic [3*CH_WIDTH-1:0]   rgb,
   output logic                    done
);

   localparam int W = CH_WIDTH;
   localparam logic [W-1:0] STEP_W = W'(STEP);

   typedef enum logic {
      IDLE = 1'b0,
      FADE = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [3*W-1:0]   rgb_q, rgb_d;
   logic [3*W-1:0]   tgt_q, tgt_d;
   logic             done_q, done_d;
   logic [3*W-1:0]   pal;
   logic [3*W-1:0]   fade_rgb;

   function automatic logic [W-1:0] step_ch(
      input logic [W-1:0] cur,
      input logic [W-1:0] tgt
   );
      logic [W-1:0] res;
      res = cur;
      if (cur < tgt) begin
         res = ((tgt - cur) > STEP_W) ? cur + STEP_W : tgt;
      end else if (cur > tgt) begin
         res = ((cur - tgt) > STEP_W) ? cur - STEP_W : tgt;
      end
      return res;
   endfunction

   // Palette: each select bit drives its channel to all ones or zero.
   always_comb begin
      pal = {{W{colour[2]}}, {W{colour[1]}}, {W{colour[0]}}};
   end

   // One fade step toward the target, channels moving independently.
   always_comb begin
      fade_rgb = rgb_q;
      for (int c = 0; c < 3; c++) begin
         fade_rgb[c*W +: W] = step_ch(rgb_q[c*W +: W], tgt_q[c*W +: W]);
      end
   end

   // Next-state logic: intake in IDLE, stepping in FADE.
   always_comb begin
      state_d = state_q;
      rgb_d   = rgb_q;
      tgt_d   = tgt_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (colour_valid) begin
               tgt_d = pal;
               if (mode) begin
                  state_d = FADE;
               end else begin
                  rgb_d  = pal;
                  done_d = 1'b1;
               end
            end
         end
         FADE: begin
            if (enable) begin
               rgb_d = fade_rgb;
               if (fade_rgb == tgt_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, colour and done registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rgb_q   <= '0;
         tgt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rgb_q   <= rgb_d;
         tgt_q   <= tgt_d;
         done_q  <= done_d;
      end
   end

   assign colour_ready = (state_q == IDLE);
   assign rgb          = rgb_q;
   assign done         = done_q;

endmodule

// File: tb/tb_rgb_fader.sv
// tb_rgb_fader: directed and random stimulus for rgb_fader,
// checked every cycle against a behavioural colour model.
module tb_rgb_fader;

   localparam int STEP = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [2:0]  colour;
   logic        mode;
   logic        colour_valid;
   logic        colour_ready;
   logic [23:0] rgb;
   logic        done;

   int checks   = 0;
   int failures = 0;

   rgb_fader #(
      .CH_WIDTH (8),
      .STEP     (STEP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .colour       (colour),
      .mode         (mode),
      .colour_valid (colour_valid),
      .colour_ready (colour_ready),
      .rgb          (rgb),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model
   logic [23:0] m_rgb, m_tgt;
   bit          m_busy, m_done;

   function automatic logic [23:0] palette(input logic [2:0] c);
      logic [7:0] r, g, b;
      r = c[2] ? 8'd255 : 8'd0;
      g = c[1] ? 8'd255 : 8'd0;
      b = c[0] ? 8'd255 : 8'd0;
      return {r, g, b};
   endfunction

   function automatic logic [23:0] toward(input logic [23:0] cur,
                                          input logic [23:0] tgt);
      logic [23:0] res;
      for (int ch = 0; ch < 3; ch++) begin
         int a, b, d;
         a = int'(cur[ch*8 +: 8]);
         b = int'(tgt[ch*8 +: 8]);
         d = b - a;
         if (d > 0)      a = a + ((d < STEP) ? d : STEP);
         else if (d < 0) a = a - ((-d < STEP) ? -d : STEP);
         res[ch*8 +: 8] = a[7:0];
      end
      return res;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rgb  <= '0;
         m_tgt  <= '0;
         m_busy <= 1'b0;
         m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (colour_valid) begin
               m_tgt <= palette(colour);
               if (mode) begin
                  m_busy <= 1'b1;
               end else begin
                  m_rgb  <= palette(colour);
                  m_done <= 1'b1;
               end
            end
         end else if (enable) begin
            m_rgb <= toward(m_rgb, m_tgt);
            if (toward(m_rgb, m_tgt) == m_tgt) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("model_rgb",   32'(rgb),          32'(m_rgb));
         chk("model_ready", 32'(colour_ready), 32'(!m_busy));
         chk("model_done",  32'(done),         32'(m_done));
      end
   end

   task automatic cyc(input logic en, input logic v,
                      input logic [2:0] c, input logic m);
      enable       = en;
      colour_valid = v;
      colour       = c;
      mode         = m;
      @(negedge clk);
   endtask

   initial begin
      int n;
      int low;
      rst_n        = 1'b0;
      enable       = 1'b0;
      colour       = 3'b000;
      mode         = 1'b0;
      colour_valid = 1'b0;
      #1;
      chk("rst_rgb",   32'(rgb),          32'h0);
      chk("rst_ready", 32'(colour_ready), 32'h1);
      chk("rst_done",  32'(done),         32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Instant red
      cyc(0, 1, 3'b100, 0);
      chk("inst_rgb",   32'(rgb),          32'hFF0000);
      chk("inst_done",  32'(done),         32'h1);
      chk("inst_ready", 32'(colour_ready), 32'h1);
      cyc(0, 0, 3'b000, 0);
      chk("inst_done_drop", 32'(done), 32'h0);

      // Fade black to white
      cyc(1, 1, 3'b000, 0);
      cyc(1, 1, 3'b111, 1);
      low = 0;
      if (colour_ready === 1'b0) low++;
      chk("fade_hold", 32'(rgb), 32'h0);
      for (int k = 1; k <= 16; k++) begin
         cyc(1, 0, 3'b000, 0);
         if (colour_ready === 1'b0) low++;
         if (k == 1)  chk("fade_e1",  32'(rgb), 32'h101010);
         if (k == 15) begin
            chk("fade_e15",  32'(rgb),  32'hF0F0F0);
            chk("fade_nodn", 32'(done), 32'h0);
         end
         if (k == 16) begin
            chk("fade_e16",  32'(rgb),  32'hFFFFFF);
            chk("fade_done", 32'(done), 32'h1);
         end
      end
      chk("fade_ready_low", 32'(low), 32'd16);

      // Enable gap, with an ignored colour offered while busy
      cyc(1, 1, 3'b000, 0);
      cyc(1, 1, 3'b111, 1);
      n = 0;
      repeat (4) begin cyc(1, 0, 3'b000, 0); n++; end
      chk("gap_pre", 32'(rgb), 32'h404040);
      repeat (5) begin
         cyc(0, 1, 3'b010, 1);
         chk("gap_frozen", 32'(rgb),  32'h404040);
         chk("gap_nodone", 32'(done), 32'h0);
      end
      do begin
         cyc(1, 0, 3'b000, 0);
         n++;
      end while (done !== 1'b1 && n < 40);
      chk("gap_edges", 32'(n),   32'd16);
      chk("gap_final", 32'(rgb), 32'hFFFFFF);

      // Null fade to the current colour
      cyc(1, 1, 3'b111, 1);
      chk("null_busy", 32'(colour_ready), 32'h0);
      cyc(1, 0, 3'b000, 0);
      chk("null_done", 32'(done), 32'h1);
      chk("null_rgb",  32'(rgb),  32'hFFFFFF);

      // Mixed: white to blue
      cyc(1, 1, 3'b001, 1);
      n = 0;
      do begin
         cyc(1, 0, 3'b000, 0);
         n++;
         if (n == 8) chk("mix_e8", 32'(rgb), 32'h7F7FFF);
      end while (done !== 1'b1 && n < 40);
      chk("mix_edges", 32'(n),   32'd16);
      chk("mix_final", 32'(rgb), 32'h0000FF);

      // Reset in the middle of a fade
      cyc(1, 1, 3'b110, 1);
      repeat (3) cyc(1, 0, 3'b000, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_rgb",   32'(rgb),          32'h0);
      chk("mid_rst_ready", 32'(colour_ready), 32'h1);
      chk("mid_rst_done",  32'(done),         32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom % 4) != 0, ($urandom % 3) == 0,
             3'($urandom), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
